// File: rtl/cmp_event_tracker_if.sv
// cmp_event_tracker_if: comparator result bus (valid strobe plus one-hot gt/lt/eq flags).
interface cmp_event_tracker_if;
    logic in_valid;
    logic a_gt_b;
    logic a_lt_b;
    logic a_eq_b;

    modport master (output in_valid, a_gt_b, a_lt_b, a_eq_b);
    modport slave  (input  in_valid, a_gt_b, a_lt_b, a_eq_b);
endinterface

// File: rtl/cmp_event_tracker.sv
// cmp_event_tracker: debounced HIGH/LOW tracker with rise/fall pulses, saturating counters and sticky irq.
// Define CMP_TRACK_ONEHOT_CHECK_EN to flag non-one-hot samples on err_o and treat them as EQ.
module cmp_event_tracker #(
    parameter int DEBOUNCE  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cmp_event_tracker_if.slave   cmp,
    input  logic                 clr,
    output logic [1:0]           state_o,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] rise_count,
    output logic [CNT_WIDTH-1:0] fall_count,
    output logic                 irq,
    output logic                 err_o
);
    typedef enum logic [1:0] {ST_UNK = 2'b00, ST_LOW = 2'b01, ST_HIGH = 2'b10} state_t;
    typedef enum logic [1:0] {C_NONE = 2'b00, C_GT = 2'b01, C_LT = 2'b10} cand_t;

    localparam logic [7:0]           DB   = 8'(DEBOUNCE);
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;
    localparam logic [CNT_WIDTH-1:0] CONE = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    cand_t                 cand_q, cand_d;
    logic [7:0]            dbc_q, dbc_d;
    logic                  rise_q, rise_d, fall_q, fall_d, irq_q, irq_d, err_q, err_d;
    logic [CNT_WIDTH-1:0]  rcnt_q, rcnt_d, fcnt_q, fcnt_d;
    logic                  is_gt, is_lt, bad;

`ifdef CMP_TRACK_ONEHOT_CHECK_EN
    assign bad   = !$onehot({cmp.a_gt_b, cmp.a_lt_b, cmp.a_eq_b});
    assign is_gt = !bad && cmp.a_gt_b;
    assign is_lt = !bad && cmp.a_lt_b;
`else
    assign bad   = 1'b0;
    assign is_gt = cmp.a_gt_b;
    assign is_lt = !cmp.a_gt_b && cmp.a_lt_b;
`endif

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        dbc_d   = dbc_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        err_d   = 1'b0;
        rcnt_d  = clr ? '0 : rcnt_q;
        fcnt_d  = clr ? '0 : fcnt_q;
        irq_d   = clr ? 1'b0 : irq_q;
        if (cmp.in_valid) begin
            err_d  = bad;
            cand_d = is_gt ? C_GT : is_lt ? C_LT : C_NONE;
            dbc_d  = cand_d == C_NONE ? 8'd0 : cand_d != cand_q ? 8'd1 : dbc_q < DB ? dbc_q + 8'd1 : DB;
            // Leaving UNKNOWN only sets the level; real events need a known prior level.
            if (dbc_d == DB && cand_d == C_GT && state_q != ST_HIGH) begin
                state_d = ST_HIGH;
                if (state_q == ST_LOW) begin
                    rise_d = 1'b1;
                    irq_d  = 1'b1;
                    rcnt_d = clr ? CONE : rcnt_q == CMAX ? CMAX : rcnt_q + CONE;
                end
            end
            if (dbc_d == DB && cand_d == C_LT && state_q != ST_LOW) begin
                state_d = ST_LOW;
                if (state_q == ST_HIGH) begin
                    fall_d = 1'b1;
                    irq_d  = 1'b1;
                    fcnt_d = clr ? CONE : fcnt_q == CMAX ? CMAX : fcnt_q + CONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_UNK;
            cand_q  <= C_NONE;
            dbc_q   <= 8'd0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
            rcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            dbc_q   <= dbc_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
            rcnt_q  <= rcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign state_o    = state_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign rise_count = rcnt_q;
    assign fall_count = fcnt_q;
    assign irq        = irq_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_cmp_event_tracker.sv
// tb_cmp_event_tracker: directed checks of debounce, events, counters, clr, flag handling and async reset.
module tb_cmp_event_tracker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [1:0]  st, st2;
    logic        rp, fp, irq, err, rp2, fp2, irq2, err2;
    logic [15:0] rc, fc;
    logic [1:0]  rc2, fc2;
    int          passed = 0;
    int          total  = 0;

    localparam logic [2:0] GT = 3'b100, LT = 3'b010, EQ = 3'b001, NO = 3'b000, GL = 3'b110;
`ifdef CMP_TRACK_ONEHOT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    cmp_event_tracker_if bus ();

    cmp_event_tracker #(.DEBOUNCE(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmp(bus), .clr(clr), .state_o(st),
        .rise_pulse(rp), .fall_pulse(fp), .rise_count(rc), .fall_count(fc),
        .irq(irq), .err_o(err)
    );

    cmp_event_tracker #(.DEBOUNCE(1), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmp(bus), .clr(clr), .state_o(st2),
        .rise_pulse(rp2), .fall_pulse(fp2), .rise_count(rc2), .fall_count(fc2),
        .irq(irq2), .err_o(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic [2:0] f, input logic c);
        bus.in_valid = v;
        {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} = f;
        clr = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} = NO;
        #12;
        chk("rst_state", st, 2'b00);
        chk("rst_rise", rp, 0);
        chk("rst_fall", fp, 0);
        chk("rst_rcnt", rc, 0);
        chk("rst_fcnt", fc, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step(1, GT, 0);
            chk("gt_pre_state", st, 2'b00);
        end
        step(1, GT, 0);
        chk("unk_high_state", st, 2'b10);
        chk("unk_high_rise", rp, 0);
        chk("unk_high_rcnt", rc, 0);
        chk("unk_high_irq", irq, 0);

        for (int i = 0; i < 3; i++) step(1, LT, 0);
        chk("lt3_state", st, 2'b10);
        step(1, EQ, 0);
        chk("eq_state", st, 2'b10);
        for (int i = 0; i < 3; i++) step(1, LT, 0);
        chk("lt_after_eq_state", st, 2'b10);
        step(1, LT, 0);
        chk("fall_state", st, 2'b01);
        chk("fall_pulse", fp, 1);
        chk("fall_cnt", fc, 1);
        chk("fall_irq", irq, 1);
        step(0, NO, 0);
        chk("fall_pulse_end", fp, 0);
        chk("idle_state", st, 2'b01);

        step(1, GT, 0);
        step(0, GT, 0);
        step(1, GT, 0);
        step(0, GT, 0);
        step(1, GT, 0);
        chk("gap_pre_state", st, 2'b01);
        step(1, GT, 0);
        chk("gap_rise_state", st, 2'b10);
        chk("gap_rise_pulse", rp, 1);
        chk("gap_rise_cnt", rc, 1);
        step(0, NO, 0);
        chk("rise_pulse_end", rp, 0);
        step(1, GT, 0);
        chk("hold_no_refire", rp, 0);
        chk("hold_rcnt", rc, 1);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) step(1, LT, 0);
            for (int i = 0; i < 4; i++) step(1, GT, 0);
        end
        chk("rcnt5", rc, 5);
        chk("fcnt5", fc, 5);
        for (int i = 0; i < 4; i++) step(1, LT, 0);
        chk("fcnt6", fc, 6);
        for (int i = 0; i < 3; i++) step(1, GT, 0);
        step(1, GT, 1);
        chk("clr_evt_rcnt", rc, 1);
        chk("clr_evt_fcnt", fc, 0);
        chk("clr_evt_irq", irq, 1);
        chk("clr_evt_pulse", rp, 1);
        step(0, NO, 1);
        chk("clr_rcnt", rc, 0);
        chk("clr_irq", irq, 0);
        chk("clr_state", st, 2'b10);

        step(1, LT, 0);
        step(1, LT, 0);
        step(1, GL, 0);
        chk("gl_err", err, ERR_EXP);
        chk("gl_state", st, 2'b10);
        step(1, LT, 0);
        chk("err_end", err, 0);
        step(1, LT, 0);
        step(1, LT, 0);
        chk("gl_restart_state", st, 2'b10);
        step(1, LT, 0);
        chk("gl_fall_state", st, 2'b01);
        chk("gl_fall_cnt", fc, 1);
        chk("gl_fall_irq", irq, 1);

        for (int i = 0; i < 3; i++) step(1, GT, 0);
        step(1, NO, 0);
        chk("none_err", err, ERR_EXP);
        for (int i = 0; i < 3; i++) step(1, GT, 0);
        chk("none_restart_state", st, 2'b01);
        step(1, GT, 0);
        chk("none_rise_state", st, 2'b10);
        chk("none_rise_pulse", rp, 1);

        step(1, LT, 0);
        bus.in_valid = 1'b1;
        {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} = LT;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", st, 2'b00);
        chk("arst_rcnt", rc, 0);
        chk("arst_fcnt", fc, 0);
        chk("arst_irq", irq, 0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1, LT, 0);
        chk("fresh_state", st, 2'b00);
        step(1, LT, 0);
        chk("fresh_low_state", st, 2'b01);
        chk("fresh_low_pulse", fp, 0);
        chk("fresh_low_fcnt", fc, 0);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, GT, 0);
        chk("d1_state", st2, 2'b10);
        chk("d1_rcnt0", rc2, 0);
        for (int k = 1; k <= 5; k++) begin
            step(1, LT, 0);
            chk("d1_fall_pulse", fp2, 1);
            step(1, GT, 0);
            chk("sat_rise_pulse", rp2, 1);
            chk("sat_rcnt", rc2, k < 3 ? k : 3);
        end
        chk("sat_fcnt", fc2, 3);
        chk("sat_irq", irq2, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
